// File: rtl/ram_io_host_pkg.sv
// ram_io_host_pkg: address map constants and bus decode shared by the memory/I-O host.
package ram_io_host_pkg;
  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [15:0] IO_PORT_IO = 16'h0000;
  localparam logic [15:0] IO_PORT_CLK = 16'h0004;
  localparam logic [1:0] IO_SEL_BITS = 2'b11;
  localparam int RAM_SIZE = 1 << 17;
  typedef enum logic [2:0] {SEL_RAM, SEL_NONE, SEL_IO, SEL_CLK, SEL_SNAP, SEL_IO_OTHER} sel_e;
  function automatic sel_e decode(input logic [17:0] a);
    logic [17:0] off;
    off = a - IO_BASE;
    if (!a[17]) return SEL_RAM;
    if (a[17:16] != IO_SEL_BITS) return SEL_NONE;
    if (off == {2'b00, IO_PORT_IO}) return SEL_IO;
    if (off[17:2] == {2'b00, IO_PORT_CLK[15:2]}) return off[1:0] == 2'b00 ? SEL_CLK : SEL_SNAP;
    return SEL_IO_OTHER;
  endfunction
endpackage

// File: rtl/ram_io_host_if.sv
// ram_io_host_if: CPU RAM bus plus host rx / UART tx byte streams and the stop flag.
interface ram_io_host_if;
  logic [31:0] bus_a;
  logic bus_wr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic cpu_rdy;
  logic rx_valid;
  logic [7:0] rx_data;
  logic rx_ready;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready;
  logic program_end;
  modport slave (
    input bus_a, bus_wr, bus_wdata, rx_valid, rx_data, tx_ready,
    output bus_rdata, cpu_rdy, rx_ready, tx_valid, tx_data, program_end
  );
  modport master (
    output bus_a, bus_wr, bus_wdata, rx_valid, rx_data, tx_ready,
    input bus_rdata, cpu_rdy, rx_ready, tx_valid, tx_data, program_end
  );
endinterface

// File: rtl/ram_io_host_byte_fifo.sv
// ram_io_host_byte_fifo: power-of-two byte FIFO; push when full and pop when empty are ignored.
module ram_io_host_byte_fifo #(
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic [7:0] data_i,
  input logic pop_i,
  output logic [7:0] data_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_comb begin
    wp_d = do_push ? wp_q + AW'(1) : wp_q;
    rp_d = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp_q] <= data_i;
endmodule

// File: rtl/ram_io_host.sv
// ram_io_host: byte RAM with registered reads plus an I/O window (rx/tx FIFOs, cycle counter, stop latch).
module ram_io_host
  import ram_io_host_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int IN_DEPTH = 16,
  parameter int OUT_DEPTH = 16
) (
  input logic clk_in,
  input logic rst_in,
  ram_io_host_if.slave io
);
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;
  sel_e sel;
  logic rd, wr, in_pop, in_empty, in_full, out_push, out_pop, out_empty, out_full;
  logic [7:0] in_data, out_wdata, rdata_q, rdata_d;
  logic [ICW-1:0] in_count;
  logic [OCW-1:0] out_count, out_count_nx;
  logic [31:0] cnt_q, cnt_d, snap_q, snap_d;
  logic rdy_q, rdy_d, end_q, end_d;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic unused_sig;
  assign unused_sig = ^{io.bus_a[31:18], in_count};
  assign sel = decode(io.bus_a[17:0]);
  assign rd = rdy_q && !io.bus_wr;
  assign wr = rdy_q && io.bus_wr;
  assign in_pop = rd && sel == SEL_IO && !in_empty;
  assign out_push = wr && ((sel == SEL_IO && io.bus_wdata != 8'h00) || sel == SEL_CLK);
  assign out_wdata = sel == SEL_CLK ? 8'h00 : io.bus_wdata;
  assign out_pop = io.tx_valid && io.tx_ready;
  assign io.rx_ready = !in_full && !rst_in;
  assign io.tx_valid = !out_empty;
  assign io.bus_rdata = rdata_q;
  assign io.cpu_rdy = rdy_q;
  assign io.program_end = end_q;
  ram_io_host_byte_fifo #(.DEPTH(IN_DEPTH)) u_in (
    .clk(clk_in), .rst(rst_in),
    .push_i(io.rx_valid && io.rx_ready), .data_i(io.rx_data), .pop_i(in_pop),
    .data_o(in_data), .full_o(in_full), .empty_o(in_empty), .count_o(in_count)
  );
  ram_io_host_byte_fifo #(.DEPTH(OUT_DEPTH)) u_out (
    .clk(clk_in), .rst(rst_in),
    .push_i(out_push), .data_i(out_wdata), .pop_i(out_pop),
    .data_o(io.tx_data), .full_o(out_full), .empty_o(out_empty), .count_o(out_count)
  );
  always_comb begin
    rdata_d = !rd ? rdata_q :
      sel == SEL_RAM ? mem[io.bus_a[ADDR_WIDTH-1:0]] :
      sel == SEL_IO ? (in_empty ? 8'h00 : in_data) :
      sel == SEL_CLK ? cnt_q[7:0] :
      sel == SEL_SNAP ? snap_q[{io.bus_a[1:0], 3'b000} +: 8] : 8'h00;
    snap_d = rd && sel == SEL_CLK ? cnt_q : snap_q;
    cnt_d = cnt_q + 32'(rdy_q);
    end_d = end_q || (wr && sel == SEL_CLK);
    out_count_nx = out_count + OCW'(out_push && !out_full) - OCW'(out_pop);
    // readiness reflects the FIFO level after this edge, so it bites one cycle later
    rdy_d = (out_count_nx <= OCW'(OUT_DEPTH - 2)) && !end_d;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rdata_q <= '0;
      snap_q <= '0;
      cnt_q <= '0;
      end_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      snap_q <= snap_d;
      cnt_q <= cnt_d;
      end_q <= end_d;
      rdy_q <= rdy_d;
    end
  end
  always_ff @(posedge clk_in) if (wr && sel == SEL_RAM) mem[io.bus_a[ADDR_WIDTH-1:0]] <= io.bus_wdata;
endmodule

// File: doc/ram_io_host.md
# ram_io_host

Byte-wide memory-and-I/O responder on the far side of the CPU RAM bus (`mem_a`/`mem_wr`/`mem_dout`/`mem_din`). It holds a 128 KB byte RAM with one-cycle registered reads and decodes the I/O window at `mem_a[17:16]==2'b11`. The I/O window provides a UART-side input FIFO, an output FIFO, a cycle counter and the program-stop latch. It drives the CPU `rdy_in` line so that no I/O side effect is lost or duplicated while the CPU is frozen.

## Interface
- `ADDR_WIDTH`, 17: RAM byte-address width (128 KB).
- `IN_DEPTH`, 16: input FIFO entries (power of two).
- `OUT_DEPTH`, 16: output FIFO entries (power of two, ≥ 4).
- `clk_in` in 1: single clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `bus_a` in 32: CPU address (`mem_a`); only bits [17:0] decoded.
- `bus_wr` in 1: 1 = write, 0 = read (`mem_wr`).
- `bus_wdata` in 8: CPU write data (`mem_dout`).
- `bus_rdata` out 8: read data to CPU (`mem_din`), registered.
- `cpu_rdy` out 1: to CPU `rdy_in`, registered.
- `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1: host byte into input FIFO.
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1: output FIFO toward UART.
- `program_end` out 1: sticky stop flag.

## Operation
- Decode: `[17:16]==11` is I/O; `[17]==0` is RAM at `a[16:0]`; `[17:16]==10` reads 0x00 and ignores writes.
- A transaction is *accepted* only in a cycle with `cpu_rdy==1`. Every side effect requires acceptance: RAM write, FIFO push/pop, snapshot capture.
- RAM write: `mem[a]<=bus_wdata`.
- RAM read: `bus_rdata<=mem[a]`.
- 0x30000 read: pop the input FIFO and return the byte. If the FIFO is empty, return 0x00 with no pop.
- 0x30000 write: push `bus_wdata` to the output FIFO. A 0x00 byte is dropped.
- 0x30004 read: return `cycle_cnt[7:0]` and latch `snap<=cycle_cnt`.
- 0x30005/6/7 read: return `snap[15:8]`, `snap[23:16]`, `snap[31:24]`; snap is unchanged.
- 0x30004 write: push 0x00 to the output FIFO (exempt from the drop rule) and set `program_end`.
- 0x30005–7 writes and other I/O offsets: ignored; reads return 0x00.
- `cycle_cnt`: 32-bit; increments each cycle `cpu_rdy==1`; wraps to 0 after 0xFFFFFFFF.
- `cpu_rdy` next value = (output-FIFO free entries ≥ 2) AND NOT `program_end`. The ≥ 2 margin absorbs a write accepted on the cycle `cpu_rdy` falls.
- After `program_end`: `cpu_rdy` stays 0 until reset. The output FIFO keeps draining to `tx`.
- Input FIFO: `rx_ready = !in_full`. A push occurs on `rx_valid & rx_ready`.
- Output FIFO: `tx_valid = !out_empty`, `tx_data` = head. A pop occurs on `tx_valid & tx_ready`.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- CPU pop of an empty input FIFO with a same-cycle `rx` push: return 0x00; the pushed byte is stored (no bypass).

## Timing
- Address and `bus_wr` are sampled at edge N. `bus_rdata` is valid throughout cycle N+1 (CPU "read takes 2 cycles"). Writes are complete at edge N.
- `bus_rdata` holds its value when nothing is accepted, and across write cycles.
- `cpu_rdy` is a registered function of the state after edge N, so it takes effect in cycle N+1.
- Reset values: `bus_rdata=0`, `cpu_rdy=0` (goes to 1 on the first edge after reset release), `rx_ready=0` during reset, `tx_valid=0`, `program_end=0`. Counters, pointers and `snap` reset to 0.
- RAM contents are not reset.
- Reset mid-operation: the FIFOs empty instantly, and any accepted-but-unreturned read data is discarded.

## Structure
- Add to `defines.v`: `IOBase` (0x30000), `IOPortIO` (offset 0), `IOPortClk` (offset 4), `IOSelBits` (2'b11), plus the RAM size constant.
- Sub-module `byte_fifo` (parameter DEPTH): synchronous, asynchronous reset, exposes `full`, `empty`, `count`. Instantiated twice.
- Top-level logic: decode, RAM array, read mux register, counter/snapshot, ready logic.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 → `bus_rdata==0xA5` exactly one cycle after the read address.
- Push rx 0x41, 0x42; read 0x30000 three times → returns 0x41, 0x42, 0x00; `rx_ready` stays 1.
- Write 0x48, 0x00, 0x49 to 0x30000 with `tx_ready=1` → tx shows 0x48 then 0x49 only.
- After 100 accepted cycles, read 0x30004..0x30007 → bytes form `snap`, equal to the count at the 0x30004 read; a later 0x30005 read returns the same byte.
- Hold `tx_ready=0` and issue 20 writes to 0x30000 → `cpu_rdy` falls when free entries < 2; no byte is lost or duplicated; the CPU resumes after draining.
- Write to 0x30004 → tx emits 0x00, `program_end=1`, `cpu_rdy=0`. Assert `rst_in` → all outputs return to reset values.
